// File: rtl/lcd_cmd_queue_if.sv
// Handshake bundle between the core LCD write port, the command queue and lcd_ctrl.
// The slave side is the queue itself; the master side is whoever drives the queue.
interface lcd_cmd_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_wr_vld;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_rdy;
  logic              o_vld;
  logic [DATA_W-1:0] o_data;
  logic              i_rdy;
  logic [CNT_W-1:0]  o_count;
  logic              o_empty;
  logic              o_full;
  logic              o_overflow;
  logic              i_ovf_clr;

  modport slave (
    input  i_wr_vld, i_wr_data, i_rdy, i_ovf_clr,
    output o_wr_rdy, o_vld, o_data, o_count, o_empty, o_full, o_overflow
  );

  modport master (
    output i_wr_vld, i_wr_data, i_rdy, i_ovf_clr,
    input  o_wr_rdy, o_vld, o_data, o_count, o_empty, o_full, o_overflow
  );
endinterface

// File: rtl/lcd_cmd_queue.sv
// LCD command FIFO: a (DEPTH-1)-word circular RAM behind a registered head word (OREG),
// so back-to-back core writes are absorbed while lcd_ctrl drains one word per transfer.
//
// state    | meaning
// S_EMPTY  | OREG holds nothing, o_vld=0 (RAM is empty as well)
// S_LOADED | OREG holds the oldest queued word, o_vld=1
module lcd_cmd_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  lcd_cmd_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RAM_D = DEPTH - 1;
  localparam int PTR_W = (RAM_D > 1) ? $clog2(RAM_D) : 1;
  localparam logic [CNT_W-1:0] L_DEPTH    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] L_PTR_LAST = PTR_W'(RAM_D - 1);

  typedef enum logic {
    S_EMPTY  = 1'b0,
    S_LOADED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_ram [RAM_D];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;

  logic             w_loaded;
  logic             w_full;
  logic             w_wr_acc;
  logic             w_pop;
  logic             w_ram_empty;
  logic             w_load_ram;
  logic             w_load_byp;
  logic             w_ram_wr;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;

  assign w_loaded    = (r_state == S_LOADED);
  assign w_full      = (r_count == L_DEPTH);
  assign w_wr_acc    = bus.i_wr_vld && !w_full;
  assign w_pop       = w_loaded && bus.i_rdy;
  // RAM occupancy is total occupancy minus the word sitting in OREG.
  assign w_ram_empty = (r_count == {{(CNT_W-1){1'b0}}, w_loaded});

  assign w_wr_ptr_nxt = (r_wr_ptr == L_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == L_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_ram  = 1'b0;
    w_load_byp  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (!w_ram_empty) begin
          w_load_ram  = 1'b1;
          w_state_nxt = S_LOADED;
        end else if (w_wr_acc) begin
          w_load_byp  = 1'b1;
          w_state_nxt = S_LOADED;
        end
      end
      S_LOADED: begin
        if (w_pop) begin
          if (!w_ram_empty) begin
            w_load_ram = 1'b1;
          end else if (w_wr_acc) begin
            w_load_byp = 1'b1;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
      end
    endcase
  end

  // Any accepted write that does not bypass straight into OREG lands at the RAM tail.
  assign w_ram_wr = w_wr_acc && !w_load_byp;

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_ram_wr) begin
      r_ram[r_wr_ptr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_load_ram) begin
        r_data   <= r_ram[r_rd_ptr];
        r_rd_ptr <= w_rd_ptr_nxt;
      end else if (w_load_byp) begin
        r_data <= bus.i_wr_data;
      end

      if (w_ram_wr) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end

      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (bus.i_wr_vld && w_full) begin
        r_ovf <= 1'b1;
      end else if (bus.i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.o_vld      = w_loaded;
  assign bus.o_data     = r_data;
  assign bus.o_count    = r_count;
  assign bus.o_empty    = (r_count == '0);
  assign bus.o_full     = w_full;
  assign bus.o_wr_rdy   = !w_full;
  assign bus.o_overflow = r_ovf;
endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Directed bench for lcd_cmd_queue: a queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_lcd_cmd_queue;
  logic clk;
  logic rst;

  lcd_cmd_queue_if #(.DATA_W(32), .DEPTH(16)) bus ();

  lcd_cmd_queue #(.DATA_W(32), .DEPTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length, the head is its front word.
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          m_full;
  bit          m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (mq.size() == 16);
      m_pop  = (mq.size() > 0) && bus.i_rdy;
      if (bus.i_wr_vld && m_full) m_ovf = 1'b1;
      else if (bus.i_ovf_clr)     m_ovf = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (bus.i_wr_vld && !m_full) mq.push_back(bus.i_wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_vld",   32'(bus.o_vld),      32'(mq.size() != 0));
      chk("m_count", 32'(bus.o_count),    32'(mq.size()));
      chk("m_empty", 32'(bus.o_empty),    32'(mq.size() == 0));
      chk("m_full",  32'(bus.o_full),     32'(mq.size() == 16));
      chk("m_wrrdy", 32'(bus.o_wr_rdy),   32'(mq.size() < 16));
      chk("m_ovf",   32'(bus.o_overflow), 32'(m_ovf));
      if (mq.size() != 0) chk("m_data", bus.o_data, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int k;
  int cyc;
  bit was_rdy;

  initial begin
    bus.i_wr_vld  = 1'b0;
    bus.i_wr_data = '0;
    bus.i_rdy     = 1'b0;
    bus.i_ovf_clr = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step();
    chk_en = 1'b1;
    chk("rst_vld",   32'(bus.o_vld), 0);
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_empty", 32'(bus.o_empty), 1);
    chk("rst_wrrdy", 32'(bus.o_wr_rdy), 1);
    chk("rst_data",  bus.o_data, 0);
    rst = 1'b0;

    // Bypass into an empty queue
    bus.i_wr_vld = 1'b1; bus.i_wr_data = 32'h8000_0238;
    step();
    bus.i_wr_vld = 1'b0;
    chk("byp_vld",   32'(bus.o_vld), 1);
    chk("byp_data",  bus.o_data, 32'h8000_0238);
    chk("byp_count", 32'(bus.o_count), 1);
    bus.i_rdy = 1'b1;
    step();
    bus.i_rdy = 1'b0;
    chk("byp_pop_empty", 32'(bus.o_empty), 1);

    // Fill to full, overflow on the 17th word, then drain in order
    bus.i_wr_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.i_wr_data = 32'(i);
      step();
      if (i == 15) begin
        chk("fill_full",  32'(bus.o_full), 1);
        chk("fill_wrrdy", 32'(bus.o_wr_rdy), 0);
        chk("fill_noovf", 32'(bus.o_overflow), 0);
      end
    end
    bus.i_wr_vld = 1'b0;
    chk("fill_ovf",   32'(bus.o_overflow), 1);
    chk("fill_count", 32'(bus.o_count), 16);
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", bus.o_data, 32'(i));
      step();
    end
    bus.i_rdy = 1'b0;
    chk("drain_empty", 32'(bus.o_empty), 1);

    // Overflow clear, and set winning over a coincident clear
    bus.i_ovf_clr = 1'b1;
    step();
    bus.i_ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.o_overflow), 0);
    bus.i_wr_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.i_wr_data = 32'h100 + 32'(i);
      step();
    end
    bus.i_wr_data = 32'hDEAD; bus.i_ovf_clr = 1'b1;
    step();
    bus.i_wr_vld = 1'b0; bus.i_ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(bus.o_overflow), 1);
    chk("ovf_head",     bus.o_data, 32'h100);
    bus.i_ovf_clr = 1'b1;
    step();
    bus.i_ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(bus.o_overflow), 0);
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 16; i++) step();
    bus.i_rdy = 1'b0;
    chk("ovf_drained", 32'(bus.o_empty), 1);

    // Simultaneous push and pop at occupancy 5
    bus.i_wr_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_data = 32'h200 + 32'(i);
      step();
    end
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.i_wr_data = 32'h300 + 32'(i);
      step();
      chk("sim_count", 32'(bus.o_count), 5);
    end
    bus.i_wr_vld = 1'b0;
    chk("sim_head", bus.o_data, 32'h30F);
    for (int i = 0; i < 5; i++) step();
    bus.i_rdy = 1'b0;
    chk("sim_empty", 32'(bus.o_empty), 1);

    // Pointer wrap under random throttling
    k = 0; cyc = 0;
    bus.i_wr_vld = 1'b1;
    while (k < 40 && cyc < 2000) begin
      bus.i_wr_data = 32'h400 + 32'(k);
      bus.i_rdy     = ($urandom_range(0, 1) == 1);
      was_rdy       = bus.o_wr_rdy;
      step();
      if (was_rdy) k++;
      cyc++;
    end
    bus.i_wr_vld = 1'b0;
    chk("wrap_accepted", 32'(k), 40);
    bus.i_rdy = 1'b1;
    cyc = 0;
    while (!bus.o_empty && cyc < 100) begin
      step();
      cyc++;
    end
    bus.i_rdy = 1'b0;
    chk("wrap_empty", 32'(bus.o_empty), 1);

    // Reset in the middle of traffic with overflow set
    bus.i_wr_vld = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.i_wr_data = 32'h500 + 32'(i);
      step();
    end
    rst = 1'b1; bus.i_rdy = 1'b1;
    step();
    step();
    rst = 1'b0; bus.i_wr_vld = 1'b0; bus.i_rdy = 1'b0;
    chk("mrst_vld",   32'(bus.o_vld), 0);
    chk("mrst_count", 32'(bus.o_count), 0);
    chk("mrst_empty", 32'(bus.o_empty), 1);
    chk("mrst_ovf",   32'(bus.o_overflow), 0);
    chk("mrst_full",  32'(bus.o_full), 0);
    bus.i_wr_vld = 1'b1; bus.i_wr_data = 32'h8000_0255;
    step();
    bus.i_wr_vld = 1'b0;
    chk("mrst_byp", bus.o_data, 32'h8000_0255);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
